// File: rtl/jk_drive_ctrl_if.sv
// Target/excitation/feedback bundle between the JK drive controller and its environment.
// master: target source + external flop side; slave: the controller.
interface jk_drive_ctrl_if;
    logic       tgt_valid;
    logic       tgt_bit;
    logic       tgt_ready;
    logic       j;
    logic       k;
    logic       q_in;
    logic       match;
    logic       err;
    logic [7:0] err_cnt;

    modport master (
        output tgt_valid, tgt_bit, q_in,
        input  tgt_ready, j, k, match, err, err_cnt
    );

    modport slave (
        input  tgt_valid, tgt_bit, q_in,
        output tgt_ready, j, k, match, err, err_cnt
    );
endinterface

// File: rtl/jk_drive_ctrl.sv
// Drives an external JK flop to a requested next state, then verifies q; one target per 3 cycles.
// Latency: j/k valid 1 cycle after transfer, match/err 3 cycles after; tgt_ready low while busy.
// Optional JK_TOGGLE_PREF_EN: resolve don't-cares toward toggle (j=k=1) for state changes.
module jk_drive_ctrl (
    input  logic           clk,
    input  logic           rst,
    jk_drive_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, DRIVE = 2'd1, CHECK = 2'd2} state_t;

    state_t     state_q, state_d;
    logic       tgt_q, tgt_d;
    logic       j_q, j_d;
    logic       k_q, k_d;
    logic       match_q, match_d;
    logic       err_q, err_d;
    logic       rdy_q, rdy_d;
    logic [7:0] err_cnt_q, err_cnt_d;

    function automatic logic [1:0] excite(input logic cur, input logic nxt);
        logic [1:0] jk;
        case ({cur, nxt})
`ifdef JK_TOGGLE_PREF_EN
            2'b01:   jk = 2'b11;
            2'b10:   jk = 2'b11;
`else
            2'b01:   jk = 2'b10;
            2'b10:   jk = 2'b01;
`endif
            default: jk = 2'b00;
        endcase
        return jk;
    endfunction

    always_comb begin
        state_d   = state_q;
        tgt_d     = tgt_q;
        j_d       = 1'b0;
        k_d       = 1'b0;
        match_d   = 1'b0;
        err_d     = 1'b0;
        rdy_d     = rdy_q;
        err_cnt_d = err_cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.tgt_valid && rdy_q) begin
                    tgt_d      = bus.tgt_bit;
                    {j_d, k_d} = excite(bus.q_in, bus.tgt_bit);
                    rdy_d      = 1'b0;
                    state_d    = DRIVE;
                end
            end
            // j/k drop to hold here; the external flop samples them on this same edge
            DRIVE: state_d = CHECK;
            CHECK: begin
                match_d = (bus.q_in == tgt_q);
                err_d   = (bus.q_in != tgt_q);
                if (err_d && err_cnt_q != 8'hFF)
                    err_cnt_d = err_cnt_q + 8'd1;
                rdy_d   = 1'b1;
                state_d = IDLE;
            end
            default: begin
                rdy_d   = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            tgt_q     <= 1'b0;
            j_q       <= 1'b0;
            k_q       <= 1'b0;
            match_q   <= 1'b0;
            err_q     <= 1'b0;
            rdy_q     <= 1'b1;
            err_cnt_q <= 8'd0;
        end else begin
            state_q   <= state_d;
            tgt_q     <= tgt_d;
            j_q       <= j_d;
            k_q       <= k_d;
            match_q   <= match_d;
            err_q     <= err_d;
            rdy_q     <= rdy_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign bus.tgt_ready = rdy_q;
    assign bus.j         = j_q;
    assign bus.k         = k_q;
    assign bus.match     = match_q;
    assign bus.err       = err_q;
    assign bus.err_cnt   = err_cnt_q;
endmodule

// File: doc/jk_drive_ctrl.md
JK_DRIVE_CTRL -- requirements
Module: jk_drive_ctrl

Interface
REQ-001: clk  input  1  single clock; all state updates on rising edge.
REQ-002: rst  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-003: tgt_valid  input  1  target next-state bit offered.
REQ-004: tgt_bit  input  1  desired q value of the external JK flip-flop after the step.
REQ-005: tgt_ready  output  1  controller can accept a target bit.
REQ-006: j  output  1  J excitation to the external JK flip-flop (registered).
REQ-007: k  output  1  K excitation to the external JK flip-flop (registered).
REQ-008: q_in  input  1  q fed back from the external JK flip-flop.
REQ-009: match  output  1  one-cycle pulse: q_in equalled target at check.
REQ-010: err  output  1  one-cycle pulse: q_in differed from target at check.
REQ-011: err_cnt  output  8  count of mismatches, saturating.

Function
REQ-012: The FSM SHALL have states IDLE, DRIVE and CHECK, with IDLE entered from reset.
REQ-013: tgt_ready SHALL be 1 only in IDLE, and a transfer SHALL occur on an edge where tgt_valid=1 and tgt_ready=1.
REQ-014: On a transfer edge, the block SHALL latch tgt_bit as the target, latch q_in as the current state, load j/k from the excitation table, and move to DRIVE.
REQ-015: The excitation table (macro off) SHALL be: 0->0: j=0 k=0; 0->1: j=1 k=0; 1->0: j=0 k=1; 1->1: j=0 k=0.
REQ-016: In DRIVE, j/k SHALL hold their loaded values for exactly one cycle, so the external flop captures them on the next edge.
REQ-017: On the DRIVE edge, j and k SHALL both be forced to 0 (hold) and the FSM SHALL move to CHECK.
REQ-018: On the CHECK edge, the block SHALL compare q_in to the target, pulse match or err for one cycle, and return to IDLE.
REQ-019: On mismatch, err_cnt SHALL increment by 1 and saturate at 255 with no wrap.
REQ-020: match and err SHALL never both be 1 and SHALL be 0 outside the cycle after CHECK.
REQ-021: Throughput SHALL be one target per 3 cycles, and tgt_valid held high SHALL be accepted on the first IDLE edge after the prior CHECK.
REQ-022: tgt_valid/tgt_bit changes while tgt_ready=0 SHALL be ignored.
REQ-023: j and k SHALL be 0 in IDLE and CHECK.

Reset
REQ-024: On rst=1 at an edge, the block SHALL set state=IDLE, j=0, k=0, match=0, err=0, err_cnt=0, with tgt_ready=1 the following cycle.
REQ-025: Reset SHALL override any transfer or check on the same edge, and an in-flight step SHALL be discarded with no err_cnt update.

Configuration
REQ-026: The macro JK_TOGGLE_PREF_EN SHALL select the don't-care resolution.
REQ-027: When defined, transitions 0->1 and 1->0 SHALL drive j=1 k=1 (toggle), and 0->0 and 1->1 SHALL remain j=0 k=0.
REQ-028: When undefined, the table in REQ-015 SHALL apply.
REQ-029: All timing and handshake behaviour SHALL be identical under both settings.

Verification
REQ-030: rst=1 for 2 cycles, then 0 -> j=k=0, err_cnt=0, tgt_ready=1, match=err=0.
REQ-031: With a behavioural JK flop at q=0, targets 1,1,0,0 -> j/k pulses 10,00,01,00 (macro off) or 11,00,11,00 (macro on), four match pulses, err_cnt=0.
REQ-032: tgt_valid held high with alternating tgt_bit -> transfers exactly every 3rd edge, and tgt_ready is low for 2 cycles after each transfer.
REQ-033: q_in tied to 0, 300 targets of 1 -> 300 err pulses, err_cnt saturates and stays at 255.
REQ-034: rst asserted during DRIVE -> next cycle IDLE, j=k=0, no match/err pulse, err_cnt=0.
REQ-035: External flop reset forcing q=0 after a target-1 DRIVE -> err pulse in the cycle after CHECK, and err_cnt increments by 1.
